rpc2_ctrl_status_sched: RTL
===========================

RPC2_CTRL_STATUS_SCHED -- requirements
Module: rpc2_ctrl_status_sched

Interface
REQ-001 Parameter DRAIN_TIMEOUT, default 255, max cycles spent in DRAIN before abort (1..255, 8-bit counter).
REQ-002 Parameter QUIET_CYCLES, default 2, consecutive cycles both active flags SHALL be low before grant (1..7).
REQ-003 AXIr_ACLK  input  1  register-domain clock; all logic SHALL be clocked on its rising edge only.
REQ-004 AXIr_ARESETN  input  1  reset; synchronous, active-low.
REQ-005 mem_rd_active, mem_wr_active  input  1 each  synchronized memory-side activity flags.
REQ-006 mem_wr_dec_status, mem_wr_slv_status, mem_wr_rsto_status, mem_rd_dec_status, mem_rd_slv_status, mem_rd_rsto_status, mem_rd_stall_status  input  1 each  synchronized error/stall levels.
REQ-007 sts_clr  input  8  one-cycle write-1-to-clear mask for status.
REQ-008 ien_we  input  1  interrupt-enable write strobe; ien_wdata  input  8  new enable value.
REQ-009 cfg_req  input  1  level request to update controller configuration; cfg_done  input  1  one-cycle pulse, update finished.
REQ-010 status  output  8  sticky status: [0] wr_dec [1] wr_slv [2] wr_rsto [3] rd_dec [4] rd_slv [5] rd_rsto [6] rd_stall [7] cfg_timeout.
REQ-011 ien  output  8  interrupt enable register.
REQ-012 irq  output  1  registered interrupt.
REQ-013 xfer_hold  output  1  blocks acceptance of new AXI transactions.
REQ-014 cfg_grant  output  1  configuration may be written; cfg_err  output  1  one-cycle pulse on drain timeout.
REQ-015 sched_state  output  2  current FSM state encoding (IDLE=0, DRAIN=1, GRANT=2, RELEASE=3).

Function
REQ-016 Each status input SHALL be registered once; a rising edge (current 1, previous 0) SHALL set the matching status bit the following cycle.
REQ-017 Input held high SHALL set its bit once; after a clear it SHALL NOT re-set until a new rising edge.
REQ-018 status bit with sts_clr bit 1 SHALL clear next cycle; simultaneous set and clear on same bit: set wins.
REQ-019 ien_we SHALL load ien from ien_wdata next cycle; ien holds otherwise.
REQ-020 irq SHALL equal registered |(status & ien), i.e. one cycle after status/ien change.
REQ-021 IDLE: xfer_hold=0, cfg_grant=0; cfg_req=1 -> DRAIN next cycle.
REQ-022 DRAIN: xfer_hold=1; quiet counter increments each cycle both active flags low, resets to 0 on any high.
REQ-023 DRAIN: quiet counter reaching QUIET_CYCLES -> GRANT next cycle.
REQ-024 DRAIN: timeout counter increments each cycle; reaching DRAIN_TIMEOUT without grant -> IDLE, cfg_err pulse, status[7] set; quiet condition wins if both occur same cycle.
REQ-025 DRAIN: cfg_req dropping -> IDLE next cycle, no error.
REQ-026 GRANT: xfer_hold=1, cfg_grant=1; cfg_done=1 or cfg_req=0 -> RELEASE.
REQ-027 RELEASE: xfer_hold=1, cfg_grant=0 for exactly one cycle -> IDLE; new cfg_req accepted only from IDLE.
REQ-028 Activity flag rising during GRANT SHALL NOT revoke grant (hold guarantees none legitimately start).
REQ-029 Quiet and timeout counters SHALL clear on every entry to DRAIN; counters saturate, never wrap.
REQ-030 cfg_done outside GRANT SHALL be ignored.

Reset
REQ-031 AXIr_ARESETN=0 sampled at a clock edge SHALL force: status=0, ien=0, irq=0, xfer_hold=0, cfg_grant=0, cfg_err=0, sched_state=IDLE, edge-detect registers=0, counters=0.
REQ-032 Reset asserted in any FSM state SHALL return to IDLE next edge; no cfg_err pulse generated.
REQ-033 An input already high when reset deasserts SHALL set its status bit one cycle after first post-reset edge (edge registers reset to 0).

Verification
REQ-034 Pulse mem_rd_slv_status 1 cycle, ien=8'h10 -> status=8'h10 next cycle, irq=1 one cycle later; sts_clr=8'h10 -> status=0, irq=0 one cycle after.
REQ-035 Hold mem_wr_dec_status high, issue sts_clr=8'h01 while high -> status[0]=0 and stays 0; toggle low/high -> status[0]=1.
REQ-036 Same cycle rising edge of mem_rd_stall_status and sts_clr=8'h40 -> status[6]=1.
REQ-037 cfg_req=1, mem_wr_active high 5 cycles then low -> DRAIN with xfer_hold=1, cfg_grant=1 exactly QUIET_CYCLES=2 cycles after active falls plus transition cycle; cfg_done -> RELEASE 1 cycle -> IDLE, xfer_hold=0.
REQ-038 DRAIN_TIMEOUT=8, mem_rd_active held high -> after 8 DRAIN cycles cfg_err one-cycle pulse, status[7]=1, state IDLE, cfg_grant never 1.
REQ-039 Reset asserted during GRANT -> next edge all outputs zero, sched_state=0, cfg_err=0.

Source files
------------

// File: rtl/rpc2_ctrl_status_sched.sv
// Sticky error/stall status with interrupt generation, plus a drain/grant scheduler
// that quiesces AXI traffic before the controller configuration is rewritten.
module rpc2_ctrl_status_sched #(
    parameter int DRAIN_TIMEOUT = 255,
    parameter int QUIET_CYCLES  = 2
) (
    input  logic       AXIr_ACLK,
    input  logic       AXIr_ARESETN,
    input  logic       mem_rd_active,
    input  logic       mem_wr_active,
    input  logic       mem_wr_dec_status,
    input  logic       mem_wr_slv_status,
    input  logic       mem_wr_rsto_status,
    input  logic       mem_rd_dec_status,
    input  logic       mem_rd_slv_status,
    input  logic       mem_rd_rsto_status,
    input  logic       mem_rd_stall_status,
    input  logic [7:0] sts_clr,
    input  logic       ien_we,
    input  logic [7:0] ien_wdata,
    input  logic       cfg_req,
    input  logic       cfg_done,
    output logic [7:0] status,
    output logic [7:0] ien,
    output logic       irq,
    output logic       xfer_hold,
    output logic       cfg_grant,
    output logic       cfg_err,
    output logic [1:0] sched_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRAIN   = 2'd1,
        S_GRANT   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [2:0] QUIET_LIM = 3'(QUIET_CYCLES);
    localparam logic [7:0] TMO_LIM   = 8'(DRAIN_TIMEOUT);

    logic [6:0] lvl_raw;
    logic [6:0] lvl_q;
    logic [6:0] lvl_prev_q;
    logic [7:0] status_q;
    logic [7:0] status_d;
    logic [7:0] ien_q;
    logic       irq_q;

    state_t     state_q;
    logic [2:0] quiet_q;
    logic [2:0] quiet_inc;
    logic [7:0] tmo_q;
    logic [7:0] tmo_inc;
    logic       hold_q;
    logic       grant_q;
    logic       err_q;
    logic       quiet_done;
    logic       tmo_fire;

    assign lvl_raw = {mem_rd_stall_status, mem_rd_rsto_status, mem_rd_slv_status,
                      mem_rd_dec_status, mem_wr_rsto_status, mem_wr_slv_status,
                      mem_wr_dec_status};

    always_comb begin
        quiet_inc  = (quiet_q == 3'd7) ? quiet_q : quiet_q + 3'd1;
        tmo_inc    = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
        quiet_done = (quiet_q >= QUIET_LIM);
        // A reached quiet window takes priority over a timeout in the same cycle.
        tmo_fire   = (state_q == S_DRAIN) && cfg_req && !quiet_done && (tmo_inc >= TMO_LIM);
        // Clear first, then OR in new events so a coincident set wins.
        status_d   = (status_q & ~sts_clr) | {tmo_fire, lvl_q & ~lvl_prev_q};
    end

    always_ff @(posedge AXIr_ACLK) begin
        if (!AXIr_ARESETN) begin
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            status_q   <= '0;
            ien_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            lvl_q      <= lvl_raw;
            lvl_prev_q <= lvl_q;
            status_q   <= status_d;
            irq_q      <= |(status_q & ien_q);
            if (ien_we) begin
                ien_q <= ien_wdata;
            end
        end
    end

    always_ff @(posedge AXIr_ACLK) begin
        if (!AXIr_ARESETN) begin
            state_q <= S_IDLE;
            quiet_q <= '0;
            tmo_q   <= '0;
            hold_q  <= 1'b0;
            grant_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cfg_req) begin
                        state_q <= S_DRAIN;
                        quiet_q <= '0;
                        tmo_q   <= '0;
                        hold_q  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    quiet_q <= (mem_rd_active || mem_wr_active) ? 3'd0 : quiet_inc;
                    tmo_q   <= tmo_inc;
                    if (!cfg_req) begin
                        state_q <= S_IDLE;
                        hold_q  <= 1'b0;
                    end else if (quiet_done) begin
                        state_q <= S_GRANT;
                        grant_q <= 1'b1;
                    end else if (tmo_fire) begin
                        state_q <= S_IDLE;
                        hold_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (cfg_done || !cfg_req) begin
                        state_q <= S_RELEASE;
                        grant_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    hold_q  <= 1'b0;
                    grant_q <= 1'b0;
                end
            endcase
        end
    end

    assign status      = status_q;
    assign ien         = ien_q;
    assign irq         = irq_q;
    assign xfer_hold   = hold_q;
    assign cfg_grant   = grant_q;
    assign cfg_err     = err_q;
    assign sched_state = state_q;

endmodule
